// File: rtl/difftest_step_batcher_pkg.sv
// Shared types and helpers for the deferred-result step batcher.
`ifndef CONFIG_DIFFTEST_STEPWIDTH
`define CONFIG_DIFFTEST_STEPWIDTH 8
`endif

package difftest_step_pkg;

    localparam int STEP_W_DEFAULT = `CONFIG_DIFFTEST_STEPWIDTH;
    localparam int MAX_STEP       = (1 << STEP_W_DEFAULT) - 1;

    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_e;

    // Clamp an accumulated count to the largest value one step beat can carry.
    function automatic logic [31:0] sat_step(input logic [31:0] sum, input logic [31:0] max_step);
        return (sum > max_step) ? max_step : sum;
    endfunction

endpackage

// File: rtl/difftest_step_batcher_if.sv
// Commit-in / step-out bundle between the core, the batcher and deferred control.
interface difftest_step_batcher_if #(
    parameter int STEP_W  = 8,
    parameter int COUNT_W = 4
);
    logic               commit_valid;
    logic [COUNT_W-1:0] commit_count;
    logic               flush_req;
    logic [7:0]         simv_result;
    logic [STEP_W-1:0]  step;
    logic               flush_done;
    logic               halted;
    logic [7:0]         halt_code;
    logic               dropped;

    modport master (
        output commit_valid, commit_count, flush_req, simv_result,
        input  step, flush_done, halted, halt_code, dropped
    );

    modport slave (
        input  commit_valid, commit_count, flush_req, simv_result,
        output step, flush_done, halted, halt_code, dropped
    );
endinterface

// File: rtl/difftest_step_batcher_timer.sv
// Idle counter: counts cycles since the last emission, saturating at TIMEOUT-1.
module difftest_step_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int TW = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || clear)
            count <= '0;
        else if (enable && count != LAST)
            count <= count + 1'b1;
    end

    assign expire = (count == LAST);
endmodule

// File: rtl/difftest_step_batcher.sv
// Batches per-cycle commit counts into nonzero step beats; drains on flush, freezes on a
// nonzero software result.
module difftest_step_batcher
    import difftest_step_pkg::*;
#(
    parameter int STEP_W  = STEP_W_DEFAULT,
    parameter int COUNT_W = 4,
    parameter int BATCH   = 64,
    parameter int TIMEOUT = 1024
) (
    input logic                    clock,
    input logic                    reset,
    difftest_step_batcher_if.slave io
);
    localparam int AW = STEP_W + COUNT_W + 1;
    localparam logic [AW-1:0] MAX_S   = {{(AW-STEP_W){1'b0}}, {STEP_W{1'b1}}};
    localparam logic [AW-1:0] BATCH_A = AW'(BATCH);

    state_e        state, state_nxt;
    logic [AW-1:0] acc, acc_nxt, sum, e;
    logic          emit, done, halt_now, expire;

    assign sum = acc + (io.commit_valid ? AW'(io.commit_count) : '0);
    assign e   = AW'(sat_step(32'(sum), 32'(MAX_S)));

    difftest_step_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (emit || state == DRAIN),
        .enable (state == RUN),
        .expire (expire)
    );

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        emit      = 1'b0;
        done      = 1'b0;
        halt_now  = 1'b0;
        case (state)
            RUN: begin
                acc_nxt = sum;
                if (io.simv_result != 8'd0) begin
                    halt_now  = 1'b1;
                    state_nxt = HALT;
                end else if (io.flush_req) begin
                    // Empty flush completes immediately without entering DRAIN.
                    if (sum != '0) begin
                        emit      = 1'b1;
                        state_nxt = DRAIN;
                    end else begin
                        done = 1'b1;
                    end
                end else if (sum >= BATCH_A || (expire && sum != '0)) begin
                    emit = 1'b1;
                end
            end
            DRAIN: begin
                acc_nxt = sum;
                if (io.simv_result != 8'd0) begin
                    halt_now  = 1'b1;
                    state_nxt = HALT;
                end else if (sum != '0) begin
                    emit = 1'b1;
                end else begin
                    done      = 1'b1;
                    state_nxt = RUN;
                end
            end
            HALT: ;
            default: state_nxt = RUN;
        endcase
        if (emit)
            acc_nxt = sum - e;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= RUN;
            acc           <= '0;
            io.step       <= '0;
            io.flush_done <= 1'b0;
            io.halted     <= 1'b0;
            io.halt_code  <= 8'd0;
            io.dropped    <= 1'b0;
        end else begin
            state         <= state_nxt;
            acc           <= acc_nxt;
            io.step       <= emit ? e[STEP_W-1:0] : '0;
            io.flush_done <= done;
            if (halt_now) begin
                io.halted    <= 1'b1;
                io.halt_code <= io.simv_result;
            end
            if (state == HALT && io.commit_valid && io.commit_count != '0)
                io.dropped <= 1'b1;
        end
    end
endmodule

// File: tb/tb_difftest_step_batcher.sv
// Scoreboard bench: expected step beats are queued with their cycle when stimulus is driven.
module tb_difftest_step_batcher;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    difftest_step_batcher_if #(.STEP_W(8), .COUNT_W(4)) m_if ();
    difftest_step_batcher_if #(.STEP_W(8), .COUNT_W(4)) s_if ();

    difftest_step_batcher #(.STEP_W(8), .COUNT_W(4), .BATCH(64), .TIMEOUT(1024)) dut (
        .clock (clock), .reset (reset), .io (m_if)
    );
    // Second instance with a batch threshold that lets the accumulator pass MAX_STEP.
    difftest_step_batcher #(.STEP_W(8), .COUNT_W(4), .BATCH(255), .TIMEOUT(1024)) dut_sat (
        .clock (clock), .reset (reset), .io (s_if)
    );

    typedef struct { int cyc; int val; } exp_t;
    exp_t expq[$];

    int      errors = 0;
    int      checks = 0;
    int      cyc = 0;
    int      rst_cyc = 0;
    bit      free_mode = 1'b0;
    longint  step_total = 0;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin : monitor
        exp_t x;
        if (!reset && m_if.step != 8'd0) begin
            step_total += m_if.step;
            if (!free_mode) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_step cyc=%0d got=%0d want none", cyc, m_if.step);
                end else begin
                    x = expq.pop_front();
                    if (x.val != int'(m_if.step) || x.cyc != cyc) begin
                        errors++;
                        $display("FAIL step cyc=%0d got=%0d want=%0d at cyc %0d", cyc, m_if.step, x.val, x.cyc);
                    end
                end
            end
        end
    end

    task automatic drive(input bit v, input int c, input bit f, input logic [7:0] r);
        @(negedge clock);
        m_if.commit_valid = v;
        m_if.commit_count = 4'(c);
        m_if.flush_req    = f;
        m_if.simv_result  = r;
    endtask

    task automatic idle();
        drive(1'b0, 0, 1'b0, 8'd0);
    endtask

    task automatic push(input int val);
        exp_t x;
        x.cyc = cyc + 1;
        x.val = val;
        expq.push_back(x);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        m_if.commit_valid = 1'b0; m_if.commit_count = '0; m_if.flush_req = 1'b0; m_if.simv_result = '0;
        s_if.commit_valid = 1'b0; s_if.commit_count = '0; s_if.flush_req = 1'b0; s_if.simv_result = '0;
        repeat (2) @(negedge clock);
        reset   = 1'b0;
        rst_cyc = cyc;
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_steps got=%0d pending want 0", name, expq.size());
        end
        expq.delete();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clock);
        checks++;
        if ({m_if.step, m_if.flush_done, m_if.halted, m_if.halt_code, m_if.dropped, s_if.step} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got step=%0d fd=%b h=%b hc=%0d d=%b want all 0",
                     m_if.step, m_if.flush_done, m_if.halted, m_if.halt_code, m_if.dropped);
        end
    endtask

    task automatic test_batch();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 4, 1'b0, 8'd0);
            if (i == 15) push(64);
        end
        repeat (4) idle();
        check_drained("batch");
        // Nothing left behind: an empty flush completes the next cycle.
        drive(1'b0, 0, 1'b1, 8'd0);
        idle();
        checks++;
        if (m_if.flush_done !== 1'b1) begin
            errors++;
            $display("FAIL batch_acc_zero flush_done got=%b want 1", m_if.flush_done);
        end
        idle();
        check_drained("batch_flush");
    endtask

    task automatic test_timeout();
        do_reset();
        drive(1'b1, 3, 1'b0, 8'd0);
        begin
            exp_t x;
            x.cyc = rst_cyc + 1024;
            x.val = 3;
            expq.push_back(x);
        end
        repeat (1030) idle();
        check_drained("timeout");
        // An empty accumulator never emits on timer expiry.
        repeat (1100) idle();
        check_drained("timeout_empty");
    endtask

    task automatic sat_cycle(input int c, input int exp_step);
        @(negedge clock);
        checks++;
        if (s_if.step !== 8'(exp_step)) begin
            errors++;
            $display("FAIL saturate step got=%0d want=%0d cyc=%0d", s_if.step, exp_step, cyc);
        end
        s_if.commit_valid = (c != 0);
        s_if.commit_count = 4'(c);
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 16; i++) sat_cycle(15, 0);
        sat_cycle(10, 0);                       // acc reaches 250
        sat_cycle(15, 0);                       // 265 -> step 255, carry 10
        sat_cycle(15, 255);
        for (int i = 0; i < 15; i++) sat_cycle(15, 0);
        sat_cycle(5, 0);                        // 10 + 240 + 5 = 255 only with the carry
        sat_cycle(0, 255);
        sat_cycle(0, 0);
    endtask

    task automatic test_flush();
        int k;
        do_reset();
        drive(1'b1, 15, 1'b0, 8'd0);
        drive(1'b1, 15, 1'b0, 8'd0);
        drive(1'b1, 7, 1'b0, 8'd0);
        drive(1'b0, 0, 1'b1, 8'd0);
        push(37);
        for (k = 0; k < 3; k++) begin
            idle();
            checks++;
            if (m_if.flush_done !== (k == 1)) begin
                errors++;
                $display("FAIL flush_done k=%0d got=%b want=%b", k, m_if.flush_done, (k == 1));
            end
        end
        // Back in RUN: a normal batch follows.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 4, 1'b0, 8'd0);
            if (i == 15) push(64);
        end
        repeat (3) idle();
        check_drained("flush");
    endtask

    task automatic test_halt();
        do_reset();
        for (int i = 0; i < 15; i++) drive(1'b1, 4, 1'b0, 8'd0);
        drive(1'b1, 4, 1'b0, 8'h02);            // emission due, halt wins
        idle();
        checks++;
        if (m_if.halted !== 1'b1 || m_if.halt_code !== 8'h02 || m_if.dropped !== 1'b0) begin
            errors++;
            $display("FAIL halt_entry got h=%b hc=%0d d=%b want 1 2 0", m_if.halted, m_if.halt_code, m_if.dropped);
        end
        drive(1'b0, 0, 1'b0, 8'h05);
        drive(1'b0, 0, 1'b1, 8'd0);
        idle();
        checks++;
        if (m_if.halt_code !== 8'h02 || m_if.flush_done !== 1'b0) begin
            errors++;
            $display("FAIL halt_sticky got hc=%0d fd=%b want 2 0", m_if.halt_code, m_if.flush_done);
        end
        for (int i = 0; i < 10; i++) drive(1'b1, 15, 1'b0, 8'd0);
        idle();
        checks++;
        if (m_if.dropped !== 1'b1 || m_if.halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_dropped got d=%b h=%b want 1 1", m_if.dropped, m_if.halted);
        end
        repeat (3) idle();
        check_drained("halt");
        // A step registered before the halt decision still appears.
        do_reset();
        checks++;
        if (m_if.halted !== 1'b0 || m_if.halt_code !== 8'd0 || m_if.dropped !== 1'b0) begin
            errors++;
            $display("FAIL reset_after_halt got h=%b hc=%0d d=%b want 0 0 0", m_if.halted, m_if.halt_code, m_if.dropped);
        end
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 4, 1'b0, 8'd0);
            if (i == 15) push(64);
        end
        drive(1'b0, 0, 1'b0, 8'h09);
        idle();
        checks++;
        if (m_if.halted !== 1'b1 || m_if.halt_code !== 8'h09) begin
            errors++;
            $display("FAIL halt_after_step got h=%b hc=%0d want 1 9", m_if.halted, m_if.halt_code);
        end
        check_drained("halt_after_step");
    endtask

    task automatic test_reset_midop();
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 15, 1'b0, 8'd0);
        do_reset();
        drive(1'b0, 0, 1'b1, 8'd0);
        idle();
        checks++;
        if (m_if.flush_done !== 1'b1) begin
            errors++;
            $display("FAIL reset_midop_flush got fd=%b want 1", m_if.flush_done);
        end
        repeat (3) idle();
        check_drained("reset_midop");
    endtask

    task automatic test_random();
        longint commit_total = 0;
        bit     seen = 1'b0;
        do_reset();
        free_mode  = 1'b1;
        step_total = 0;
        for (int i = 0; i < 3000; i++) begin
            bit v;
            int c;
            v = ($urandom_range(0, 3) != 0);
            c = $urandom_range(0, 15);
            drive(v, c, ($urandom_range(0, 49) == 0), 8'd0);
            if (v) commit_total += c;
        end
        drive(1'b0, 0, 1'b1, 8'd0);
        for (int i = 0; i < 100 && !seen; i++) begin
            idle();
            seen = m_if.flush_done;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL random_drain_timeout got no flush_done want pulse within 100 cycles");
        end
        idle();
        checks++;
        if (step_total != commit_total) begin
            errors++;
            $display("FAIL random_conservation got steps=%0d want commits=%0d", step_total, commit_total);
        end
        free_mode = 1'b0;
    endtask

    initial begin
        m_if.commit_valid = 1'b0; m_if.commit_count = '0; m_if.flush_req = 1'b0; m_if.simv_result = '0;
        s_if.commit_valid = 1'b0; s_if.commit_count = '0; s_if.flush_req = 1'b0; s_if.simv_result = '0;
        test_reset();
        test_batch();
        test_timeout();
        test_saturate();
        test_flush();
        test_halt();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
